// File: rtl/fan_tach_if.sv
// Fan tachometer monitor bus: raw tach/enable in, window count and health flags out.
interface fan_tach_if #(
  parameter int unsigned CNT_W = 16
);
  logic             tach_i;
  logic             enable_i;
  logic [CNT_W-1:0] tach_count_o;
  logic             count_valid_o;
  logic             stall_o;
  logic             low_speed_o;

  modport master (
    output tach_i, enable_i,
    input  tach_count_o, count_valid_o, stall_o, low_speed_o
  );

  modport slave (
    input  tach_i, enable_i,
    output tach_count_o, count_valid_o, stall_o, low_speed_o
  );
endinterface

// File: rtl/fan_tach_mon.sv
// Fan tach monitor: synchronise and glitch-filter tach, count falling edges per
// fixed window, report the count each window and flag stalled or slow fans.
module fan_tach_mon #(
  parameter int unsigned WINDOW_CYCLES = 50000000,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned FILT_LEN      = 4,
  parameter int unsigned STALL_WINDOWS = 2,
  parameter int unsigned MIN_COUNT     = 10
) (
  input  logic       clk,
  input  logic       reset,
  fan_tach_if.slave  bus
);

  localparam int unsigned WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int unsigned FC_W  = $clog2(FILT_LEN + 1);
  localparam int unsigned ZC_W  = $clog2(STALL_WINDOWS + 1);

  localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [FC_W-1:0]  FILT_LAST = FC_W'(FILT_LEN - 1);
  localparam logic [ZC_W-1:0]  ZC_STALL  = ZC_W'(STALL_WINDOWS);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t           state;
  logic             sync1, sync2;
  logic             filt, filt_q;
  logic [FC_W-1:0]  filt_cnt;
  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] pulse_cnt;
  logic [ZC_W-1:0]  zero_cnt;

  logic             fall_c;
  logic [CNT_W-1:0] pulse_next_c;
  logic [ZC_W-1:0]  zero_next_c;

  // Filtered falling edge and the saturated running count including it.
  always_comb begin
    fall_c       = filt_q & ~filt;
    pulse_next_c = pulse_cnt;
    if (fall_c && (pulse_cnt != CNT_MAX)) pulse_next_c = pulse_cnt + CNT_W'(1);
    zero_next_c  = '0;
    if (pulse_next_c == '0) begin
      zero_next_c = (zero_cnt == ZC_STALL) ? zero_cnt : zero_cnt + ZC_W'(1);
    end
  end

  // Two-flop synchroniser and run-length glitch filter; idle level is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      filt     <= 1'b1;
      filt_q   <= 1'b1;
      filt_cnt <= '0;
    end else begin
      sync1  <= bus.tach_i;
      sync2  <= sync1;
      filt_q <= filt;
      if (sync2 != filt) begin
        if (filt_cnt == FILT_LAST) begin
          filt     <= sync2;
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + FC_W'(1);
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  // Window sequencer; tach_count_o keeps its last value while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      win_cnt           <= '0;
      pulse_cnt         <= '0;
      zero_cnt          <= '0;
      bus.tach_count_o  <= '0;
      bus.count_valid_o <= 1'b0;
      bus.stall_o       <= 1'b0;
      bus.low_speed_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          win_cnt           <= '0;
          pulse_cnt         <= '0;
          zero_cnt          <= '0;
          bus.count_valid_o <= 1'b0;
          bus.stall_o       <= 1'b0;
          bus.low_speed_o   <= 1'b0;
          if (bus.enable_i) state <= MEASURE;
        end
        MEASURE: begin
          if (!bus.enable_i) begin
            state             <= IDLE;
            win_cnt           <= '0;
            pulse_cnt         <= '0;
            zero_cnt          <= '0;
            bus.count_valid_o <= 1'b0;
            bus.stall_o       <= 1'b0;
            bus.low_speed_o   <= 1'b0;
          end else if (win_cnt == WIN_LAST) begin
            win_cnt           <= '0;
            pulse_cnt         <= '0;
            zero_cnt          <= zero_next_c;
            bus.tach_count_o  <= pulse_next_c;
            bus.count_valid_o <= 1'b1;
            bus.low_speed_o   <= (32'(pulse_next_c) < MIN_COUNT);
            bus.stall_o       <= (zero_next_c == ZC_STALL);
          end else begin
            win_cnt           <= win_cnt + WIN_W'(1);
            pulse_cnt         <= pulse_next_c;
            bus.count_valid_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fan_tach_mon.sv
// Directed bench for fan_tach_mon: main instance plus a narrow, unfiltered
// instance for counter saturation.
module tb_fan_tach_mon;

  logic clk = 1'b0;
  logic reset;

  int npulse = 5;
  bit glitch = 1'b0;
  int gcyc   = 0;
  int passed = 0;
  int total  = 0;

  fan_tach_if #(.CNT_W(8)) bus0 ();
  fan_tach_if #(.CNT_W(4)) bus1 ();

  fan_tach_mon #(
    .WINDOW_CYCLES(100), .CNT_W(8), .FILT_LEN(4), .STALL_WINDOWS(2), .MIN_COUNT(3)
  ) u_dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave)
  );

  fan_tach_mon #(
    .WINDOW_CYCLES(100), .CNT_W(4), .FILT_LEN(1), .STALL_WINDOWS(2), .MIN_COUNT(3)
  ) u_dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave)
  );

  always #5 clk = ~clk;

  // Tach waveforms: 100-cycle pattern with npulse 10-low/10-high pulses, or 2-cycle glitches.
  initial begin
    int ph;
    bus0.tach_i = 1'b1;
    bus1.tach_i = 1'b1;
    forever begin
      @(negedge clk);
      gcyc = gcyc + 1;
      ph   = gcyc % 100;
      if (glitch) bus0.tach_i = ((ph % 10) >= 2);
      else        bus0.tach_i = !(((ph % 20) < 10) && ((ph / 20) < npulse));
      bus1.tach_i = ((gcyc % 4) >= 2);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic wait_strobe0(input int budget, output int k);
    k = 0;
    do begin
      @(negedge clk);
      k = k + 1;
    end while (!bus0.count_valid_o && k < budget);
  endtask

  task automatic wait_strobe1(input int budget, output int k);
    k = 0;
    do begin
      @(negedge clk);
      k = k + 1;
    end while (!bus1.count_valid_o && k < budget);
  endtask

  initial begin
    int k;
    int seen;
    reset         = 1'b1;
    bus0.enable_i = 1'b0;
    bus1.enable_i = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    chk("rst_count", 32'(bus0.tach_count_o), 0);
    chk("rst_valid", 32'(bus0.count_valid_o), 0);
    chk("rst_stall", 32'(bus0.stall_o), 0);
    chk("rst_low", 32'(bus0.low_speed_o), 0);
    chk("rst_count1", 32'(bus1.tach_count_o), 0);

    // Nominal speed: 5 pulses per window.
    repeat (30) @(negedge clk);
    bus0.enable_i = 1'b1;
    wait_strobe0(150, k);
    chk("t1_latency", 32'(k), 101);
    chk("t1_count", 32'(bus0.tach_count_o), 5);
    chk("t1_low", 32'(bus0.low_speed_o), 0);
    chk("t1_stall", 32'(bus0.stall_o), 0);
    @(negedge clk);
    chk("t1_strobe_width", 32'(bus0.count_valid_o), 0);
    wait_strobe0(150, k);
    chk("t1_period", 32'(k), 99);
    chk("t1_count2", 32'(bus0.tach_count_o), 5);

    // Slow fan: 2 pulses per window.
    bus0.enable_i = 1'b0;
    npulse = 2;
    repeat (120) @(negedge clk);
    bus0.enable_i = 1'b1;
    wait_strobe0(150, k);
    chk("t5_latency", 32'(k), 101);
    chk("t5_count2", 32'(bus0.tach_count_o), 2);
    chk("t5_low2", 32'(bus0.low_speed_o), 1);
    chk("t5_stall2", 32'(bus0.stall_o), 0);

    // Disable mid-window: flags clear, count held, no strobe.
    repeat (40) @(negedge clk);
    bus0.enable_i = 1'b0;
    @(negedge clk);
    chk("t6_dis_valid", 32'(bus0.count_valid_o), 0);
    chk("t6_dis_low", 32'(bus0.low_speed_o), 0);
    chk("t6_dis_stall", 32'(bus0.stall_o), 0);
    chk("t6_dis_count_held", 32'(bus0.tach_count_o), 2);
    seen = 0;
    npulse = 3;
    repeat (150) begin
      @(negedge clk);
      if (bus0.count_valid_o) seen = seen + 1;
    end
    chk("t6_dis_no_strobe", 32'(seen), 0);

    // Threshold: 3 pulses is not slow; restart latency after enable.
    bus0.enable_i = 1'b1;
    wait_strobe0(150, k);
    chk("t6_restart_latency", 32'(k), 101);
    chk("t5_count3", 32'(bus0.tach_count_o), 3);
    chk("t5_low3", 32'(bus0.low_speed_o), 0);

    // Glitches only: zero count, stall on second zero window.
    bus0.enable_i = 1'b0;
    glitch = 1'b1;
    repeat (30) @(negedge clk);
    bus0.enable_i = 1'b1;
    wait_strobe0(150, k);
    chk("t2_latency", 32'(k), 101);
    chk("t2_count_w1", 32'(bus0.tach_count_o), 0);
    chk("t2_stall_w1", 32'(bus0.stall_o), 0);
    chk("t2_low_w1", 32'(bus0.low_speed_o), 1);
    wait_strobe0(150, k);
    chk("t2_count_w2", 32'(bus0.tach_count_o), 0);
    chk("t2_stall_w2", 32'(bus0.stall_o), 1);

    // Resume from stall.
    glitch = 1'b0;
    npulse = 5;
    wait_strobe0(150, k);
    chk("t3_count_4to5", 32'((bus0.tach_count_o >= 8'd4) && (bus0.tach_count_o <= 8'd5)), 1);
    chk("t3_stall", 32'(bus0.stall_o), 0);
    chk("t3_low", 32'(bus0.low_speed_o), 0);

    // Reset mid-window discards it; window restarts after reset.
    repeat (50) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t6_rst_count", 32'(bus0.tach_count_o), 0);
    chk("t6_rst_valid", 32'(bus0.count_valid_o), 0);
    chk("t6_rst_stall", 32'(bus0.stall_o), 0);
    chk("t6_rst_low", 32'(bus0.low_speed_o), 0);
    wait_strobe0(150, k);
    chk("t6_rst_latency", 32'(k), 101);
    chk("t6_rst_count_4to5", 32'((bus0.tach_count_o >= 8'd4) && (bus0.tach_count_o <= 8'd5)), 1);

    // Saturation on the 4-bit counter: 25 edges per window clamp to 15.
    bus1.enable_i = 1'b1;
    wait_strobe1(150, k);
    chk("t4_latency", 32'(k), 101);
    chk("t4_count_sat", 32'(bus1.tach_count_o), 15);
    chk("t4_low", 32'(bus1.low_speed_o), 0);
    chk("t4_stall", 32'(bus1.stall_o), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
